// File: rtl/led_status_pkg.sv
// Shared types and defaults for the status LED driver.
package led_status_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACT     = 3'd1,
    ERR_ON  = 3'd2,
    ERR_OFF = 3'd3,
    ERR_GAP = 3'd4
  } state_t;

  localparam int DEF_TICK_DIV     = 2080;  // 2.08 MHz OSCH -> 1 ms
  localparam int DEF_ACT_MS       = 50;
  localparam int DEF_HB_PERIOD_MS = 1000;
  localparam int DEF_HB_ON_MS     = 50;
  localparam int DEF_BLINK_ON_MS  = 200;
  localparam int DEF_BLINK_OFF_MS = 200;
  localparam int DEF_GAP_MS       = 1000;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // ms counters only ever hold 0..max_ms-1
  function automatic int ms_width(input int max_ms);
    return (max_ms < 2) ? 1 : $clog2(max_ms);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// 1 ms prescaler: counts 0..TICK_DIV-1, tick on the last count.
module led_tick_gen #(
  parameter int TICK_DIV = 2080
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int CW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // restart aligns the ms grid to the cycle of a state entry
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  // prescaler register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_status.sv
// Status LED: error blink code > disk activity flash > idle heartbeat.
module led_status
  import led_status_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int ACT_MS       = DEF_ACT_MS,
  parameter int HB_PERIOD_MS = DEF_HB_PERIOD_MS,
  parameter int HB_ON_MS     = DEF_HB_ON_MS,
  parameter int BLINK_ON_MS  = DEF_BLINK_ON_MS,
  parameter int BLINK_OFF_MS = DEF_BLINK_OFF_MS,
  parameter int GAP_MS       = DEF_GAP_MS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activity,
  input  logic       error_valid,
  input  logic [3:0] error_code,
  input  logic       error_clear,
  output logic       pin_led,
  output logic       error_active,
  output logic       en_245
);
  localparam int MS_MAX = max_i(max_i(max_i(ACT_MS, HB_PERIOD_MS),
                                      max_i(BLINK_ON_MS, BLINK_OFF_MS)), GAP_MS);
  localparam int MS_W = ms_width(MS_MAX);
  typedef logic [MS_W-1:0] ms_t;

  localparam ms_t HB_LAST  = ms_t'(HB_PERIOD_MS - 1);
  localparam ms_t HB_ON    = ms_t'(HB_ON_MS);
  localparam ms_t ACT_LAST = ms_t'(ACT_MS - 1);
  localparam ms_t ON_LAST  = ms_t'(BLINK_ON_MS - 1);
  localparam ms_t OFF_LAST = ms_t'(BLINK_OFF_MS - 1);
  localparam ms_t GAP_LAST = ms_t'(GAP_MS - 1);

  state_t     state_q, state_d;
  ms_t        ms_q, ms_d;
  logic [3:0] blink_q, blink_d, code_q, code_d, pend_q, pend_d;
  logic       err_q, err_d, pin_q, pin_d, run_q;
  logic       tick, enter, err_new;
  logic [3:0] blink_nx, next_code;

  // the first cycle out of reset counts as the IDLE entry so the first
  // heartbeat flash has the same length as every later one
  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (enter || !run_q),
    .tick    (tick)
  );

  assign err_new   = error_valid && (error_code != 4'd0);
  assign blink_nx  = blink_q + 4'd1;
  assign next_code = err_new ? error_code : ((pend_q != 4'd0) ? pend_q : code_q);

  // next state, ms counter, blink count and code latch
  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    blink_d = blink_q;
    code_d  = code_q;
    pend_d  = pend_q;
    err_d   = err_q;
    enter   = 1'b0;
    if (error_clear) begin
      state_d = IDLE;
      code_d  = '0;
      pend_d  = '0;
      err_d   = 1'b0;
      enter   = 1'b1;
      if (err_new) begin
        state_d = ERR_ON;
        code_d  = error_code;
        blink_d = '0;
        err_d   = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE, ACT: begin
          if (err_new) begin
            state_d = ERR_ON;
            code_d  = error_code;
            blink_d = '0;
            err_d   = 1'b1;
            enter   = 1'b1;
          end else if (activity) begin
            state_d = ACT;
            enter   = 1'b1;
          end else if (tick) begin
            if (state_q == IDLE)      ms_d = (ms_q == HB_LAST) ? '0 : ms_q + ms_t'(1);
            else if (ms_q == ACT_LAST) begin
              state_d = IDLE;
              enter   = 1'b1;
            end else                  ms_d = ms_q + ms_t'(1);
          end
        end
        ERR_ON, ERR_OFF, ERR_GAP: begin
          // a report during display only replaces the pending code
          if (err_new) pend_d = error_code;
          if (tick) begin
            ms_d = ms_q + ms_t'(1);
            if (state_q == ERR_ON && ms_q == ON_LAST) begin
              blink_d = blink_nx;
              state_d = (blink_nx == code_q) ? ERR_GAP : ERR_OFF;
              enter   = 1'b1;
            end else if (state_q == ERR_OFF && ms_q == OFF_LAST) begin
              state_d = ERR_ON;
              enter   = 1'b1;
            end else if (state_q == ERR_GAP && ms_q == GAP_LAST) begin
              state_d = ERR_ON;
              code_d  = next_code;
              pend_d  = '0;
              blink_d = '0;
              enter   = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          enter   = 1'b1;
        end
      endcase
    end
    if (enter) ms_d = '0;
  end

  // LED follows the next state so a transition shows on the next edge
  always_comb begin
    pin_d = 1'b0;
    case (state_d)
      IDLE:        pin_d = (ms_d < HB_ON);
      ACT, ERR_ON: pin_d = 1'b1;
      default:     pin_d = 1'b0;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ms_q    <= '0;
      blink_q <= '0;
      code_q  <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      pin_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      blink_q <= blink_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      pin_q   <= pin_d;
      run_q   <= 1'b1;
    end
  end

  assign pin_led      = pin_q;
  assign error_active = err_q;
  assign en_245       = 1'b1;

endmodule

// File: tb/tb_led_status.sv
// Scoreboard bench for led_status with small timing parameters.
module tb_led_status;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       activity = 1'b0;
  logic       error_valid = 1'b0;
  logic [3:0] error_code = 4'd0;
  logic       error_clear = 1'b0;
  logic       pin_led, error_active, en_245;

  int tests = 0;
  int fails = 0;

  logic [1:0] sb_val[$];
  string      sb_tag[$];

  led_status #(
    .TICK_DIV(4), .ACT_MS(3), .HB_PERIOD_MS(10), .HB_ON_MS(2),
    .BLINK_ON_MS(2), .BLINK_OFF_MS(1), .GAP_MS(5)
  ) dut (
    .clk(clk), .reset(reset), .activity(activity),
    .error_valid(error_valid), .error_code(error_code),
    .error_clear(error_clear), .pin_led(pin_led),
    .error_active(error_active), .en_245(en_245)
  );

  always #5 clk = ~clk;

  // monitor: one expected {pin_led, error_active} per clock edge
  always @(posedge clk) begin
    #1;
    if (sb_val.size() > 0) begin
      logic [1:0] e;
      string t;
      e = sb_val.pop_front();
      t = sb_tag.pop_front();
      tests++;
      if ({pin_led, error_active, en_245} !== {e, 1'b1}) begin
        fails++;
        $display("FAIL %s @%0t: got led=%b err=%b en=%b, want led=%b err=%b en=1",
                 t, $time, pin_led, error_active, en_245, e[1], e[0]);
      end
    end
  end

  task automatic step(input bit a, input bit ev, input logic [3:0] code,
                      input bit clr, input bit rst, input bit ep, input bit ee,
                      input string tag);
    @(negedge clk);
    activity    = a;
    error_valid = ev;
    error_code  = code;
    error_clear = clr;
    reset       = rst;
    sb_val.push_back({ep, ee});
    sb_tag.push_back(tag);
  endtask

  task automatic seg(input int n, input bit ep, input bit ee, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 0, 0, ep, ee, tag);
  endtask

  initial begin
    // reset state
    step(0, 0, 0, 0, 1, 0, 0, "reset");
    step(0, 0, 0, 0, 1, 0, 0, "reset");
    // heartbeat: 8 on, 32 off, repeating
    seg(8, 1, 0, "hb_on");    seg(32, 0, 0, "hb_off");
    seg(8, 1, 0, "hb_on2");   seg(10, 0, 0, "hb_off2");
    // single activity: 12 in ACT then heartbeat restarts lit for 8
    step(1, 0, 0, 0, 0, 1, 0, "act");
    seg(11, 1, 0, "act_hold"); seg(8, 1, 0, "act_hb"); seg(4, 0, 0, "act_dark");
    // retrigger 8 cycles after first pulse
    step(1, 0, 0, 0, 0, 1, 0, "retrig1");
    seg(7, 1, 0, "retrig_hold");
    step(1, 0, 0, 0, 0, 1, 0, "retrig2");
    seg(11, 1, 0, "retrig_hold2"); seg(8, 1, 0, "retrig_hb"); seg(3, 0, 0, "retrig_dark");
    // error code 3 from IDLE
    step(0, 1, 4'd3, 0, 0, 1, 1, "e3_start");
    seg(7, 1, 1, "e3_on1"); seg(4, 0, 1, "e3_off1");
    seg(8, 1, 1, "e3_on2"); seg(4, 0, 1, "e3_off2");
    seg(8, 1, 1, "e3_on3"); seg(20, 0, 1, "e3_gap");
    seg(8, 1, 1, "e3r_on1"); seg(4, 0, 1, "e3r_off1");
    // code 1 reported mid-blink becomes pending
    seg(3, 1, 1, "e3r_on2a");
    step(0, 1, 4'd1, 0, 0, 1, 1, "pend_rep");
    seg(4, 1, 1, "e3r_on2b"); seg(4, 0, 1, "e3r_off2");
    seg(8, 1, 1, "e3r_on3");  seg(20, 0, 1, "e3r_gap");
    seg(8, 1, 1, "e1_on");
    // activity during error is ignored
    step(1, 0, 0, 0, 0, 0, 1, "act_in_err");
    seg(19, 0, 1, "e1_gap");
    seg(8, 1, 1, "e1r_on");
    // pending 4 then clear+valid 2 must drop the pending code
    step(0, 1, 4'd4, 0, 0, 0, 1, "pend4");
    seg(4, 0, 1, "e1r_gap");
    step(0, 1, 4'd2, 1, 0, 1, 1, "clr_e2");
    seg(7, 1, 1, "e2_on1"); seg(4, 0, 1, "e2_off1");
    seg(8, 1, 1, "e2_on2"); seg(20, 0, 1, "e2_gap");
    seg(8, 1, 1, "e2r_on1"); seg(4, 0, 1, "e2r_off1");
    seg(8, 1, 1, "e2r_on2"); seg(2, 0, 1, "e2r_gap");
    // clear alone -> IDLE heartbeat from 0
    step(0, 0, 0, 1, 0, 1, 0, "clr");
    seg(7, 1, 0, "clr_hb"); seg(5, 0, 0, "clr_dark");
    // code 0 is ignored
    step(0, 1, 4'd0, 0, 0, 0, 0, "code0");
    seg(2, 0, 0, "code0_dark");
    // error from ACT
    step(1, 0, 0, 0, 0, 1, 0, "act2");
    seg(2, 1, 0, "act2_hold");
    step(0, 1, 4'd1, 0, 0, 1, 1, "act_to_err");
    seg(7, 1, 1, "ae_on"); seg(10, 0, 1, "ae_gap");
    step(0, 0, 0, 1, 0, 1, 0, "clr2");
    seg(1, 1, 0, "clr2_hb");
    // activity and error together: error wins
    step(1, 1, 4'd5, 0, 0, 1, 1, "act_err_tie");
    seg(3, 1, 1, "tie_on");
    // reset during ERR_ON wins over activity
    step(1, 0, 0, 0, 1, 0, 0, "rst_mid");
    seg(8, 1, 0, "post_rst_hb"); seg(2, 0, 0, "post_rst_dark");
    repeat (3) @(negedge clk);
    tests++;
    if (sb_val.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d left, want 0", sb_val.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
